mult_div: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It sits beside the ALU in the execute stage and consumes the same register-file operands, rs and rt. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. While busy it raises `busy` so the PC/control path can stall any MFHI/MFLO or new MDU instruction.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/mult_div.sv | 139 +++++++++++++
 tb/tb_mult_div.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide unit op encodings and FSM states.
// The control decoder reuses the op encodings for the MDU funct group.
package mips_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } mdu_state_t;

    function automatic logic mdu_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shared 2*WIDTH shift register serves both shift-add and restoring divide.
module mult_div
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    mdu_state_t         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;  // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;

    logic               op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_sum, rem_sh, sub_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // Datapath: one iteration step of each algorithm plus final sign fix-up.
    always_comb begin
        op_signed = mdu_is_signed(op);
        a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

        add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {add_sum, acc_q[WIDTH-1:1]};

        // Borrow out of the trial subtraction means the shifted remainder is restored.
        rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
        sub_diff  = rem_sh - {1'b0, opnd_q};
        div_next  = sub_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quot_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (op[2] == 1'b0) begin
                        is_div_d  = mdu_is_div(op);
                        neg_res_d = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = op_signed && mdu_is_div(op) && a[WIDTH-1];
                        acc_d     = mdu_is_div(op) ? {{WIDTH{1'b0}}, a_mag}
                                                   : {{WIDTH{1'b0}}, b_mag};
                        opnd_d    = mdu_is_div(op) ? b_mag : a_mag;
                        cnt_d     = '0;
                        state_d   = CALC;
                    end else if (op == MDU_MTHI) begin
                        hi_d = a;
                    end else if (op == MDU_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = is_div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
                lo_d    = is_div_q ? quot_fix : prod_fix[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// Directed self-checking bench for mult_div: hand-computed HI/LO results,
// busy/done timing, MTHI/MTLO, ignored starts while busy and mid-op reset.
module tb_mult_div;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vectors     = 0;
    int miscompares = 0;

    mult_div #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request and let the accepting edge (E0) pass.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait (bounded) for done; report edges since E0 and cycles seen busy.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    int edges, busy_cycles, done_pulses;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b110;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);

        // MTHI / MTLO are single-cycle and never raise busy or done
        issue(MDU_MTHI, 32'h1234_5678, 32'h0);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo", lo, 32'h0);
        check("mthi_busy", {31'b0, busy}, 32'h0);
        check("mthi_done", {31'b0, done}, 32'h0);
        issue(MDU_MTLO, 32'h9ABC_DEF0, 32'h0);
        check("mtlo_lo", lo, 32'h9ABC_DEF0);
        check("mtlo_hi", hi, 32'h1234_5678);

        // no-op encoding leaves everything untouched
        issue(3'b110, 32'hFFFF_FFFF, 32'h1);
        check("nop_busy", {31'b0, busy}, 32'h0);
        check("nop_hi", hi, 32'h1234_5678);
        check("nop_lo", lo, 32'h9ABC_DEF0);

        // MULTU with full timing checks
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy_e0", {31'b0, busy}, 32'h1);
        wait_done(edges, busy_cycles);
        check("multu_edges", edges, 33);
        check("multu_busy_cycles", busy_cycles, 33);
        check("multu_done", {31'b0, done}, 32'h1);
        check("multu_busy_done_cycle", {31'b0, busy}, 32'h0);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        @(posedge clk);
        #1 check("multu_done_pulse", {31'b0, done}, 32'h0);

        issue(MDU_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done(edges, busy_cycles);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        issue(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(edges, busy_cycles);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);

        issue(MDU_DIVU, 32'h0000_0007, 32'h0);
        wait_done(edges, busy_cycles);
        check("divu_zero_lo", lo, 32'hFFFF_FFFF);
        check("divu_zero_hi", hi, 32'h0000_0007);

        issue(MDU_DIV, 32'hFFFF_FFF9, 32'h0);
        wait_done(edges, busy_cycles);
        check("div_zero_neg_lo", lo, 32'h0000_0001);
        check("div_zero_neg_hi", hi, 32'hFFFF_FFF9);

        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(edges, busy_cycles);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);

        // MTLO while busy is ignored; only the multiply result lands
        issue(MDU_MULTU, 32'h0000_0006, 32'h0000_0007);
        op    = MDU_MTLO;
        a     = 32'hDEAD_BEEF;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        check("mtlo_busy_ignored", lo, 32'h8000_0000);
        wait_done(edges, busy_cycles);
        check("mtlo_busy_edges", edges, 30);
        check("mtlo_busy_lo", lo, 32'h0000_002A);
        check("mtlo_busy_hi", hi, 32'h0);

        // back-to-back: second start accepted in the done cycle
        issue(MDU_MULTU, 32'h0000_0003, 32'h0000_0005);
        wait_done(edges, busy_cycles);
        check("b2b_mul_done", {31'b0, done}, 32'h1);
        check("b2b_mul_hi", hi, 32'h0);
        check("b2b_mul_lo", lo, 32'h0000_000F);
        issue(MDU_DIVU, 32'd100, 32'd7);
        check("b2b_div_busy", {31'b0, busy}, 32'h1);
        wait_done(edges, busy_cycles);
        check("b2b_div_edges", edges, 33);
        check("b2b_div_hi", hi, 32'h0000_0002);
        check("b2b_div_lo", lo, 32'h0000_000E);

        // reset at cycle 10 of a divide discards the result
        issue(MDU_DIV, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mid_busy", {31'b0, busy}, 32'h0);
        check("rst_mid_hi", hi, 32'h0);
        check("rst_mid_lo", lo, 32'h0);
        done_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (done) done_pulses++;
        end
        check("rst_mid_no_done", done_pulses, 0);
        check("rst_mid_lo_after", lo, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
